// File: rtl/rtdf_sample_conditioner_if.sv
`default_nettype none
// ============================================================================
//  Module      : rtdf_sample_conditioner_if
//  Description : Sample stream and status bundle of the RTDF sample
//                conditioner. "master" drives samples and observes the
//                conditioned stream; "slave" is the conditioner side.
//  Revision    : 1.0  initial release
// ============================================================================
interface rtdf_sample_conditioner_if #(
    parameter int CNT_WIDTH = 16
);
    logic                 sample_valid;
    logic [2:0]           sample_data;
    logic                 out_valid;
    logic [2:0]           out_data;
    logic                 locked;
    logic                 starved;
    logic [CNT_WIDTH-1:0] dropout_count;
    logic [CNT_WIDTH-1:0] starve_count;
    logic [CNT_WIDTH-1:0] fill_count;

    modport master (
        output sample_valid,
        output sample_data,
        input  out_valid,
        input  out_data,
        input  locked,
        input  starved,
        input  dropout_count,
        input  starve_count,
        input  fill_count
    );

    modport slave (
        input  sample_valid,
        input  sample_data,
        output out_valid,
        output out_data,
        output locked,
        output starved,
        output dropout_count,
        output starve_count,
        output fill_count
    );
endinterface
`default_nettype wire

// File: rtl/rtdf_sample_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : rtdf_sample_conditioner
//  Description : Conditions the real-time Ethernet data feed sample stream:
//                declares lock after a sustained run of valid samples,
//                bridges short dropouts (holdover), declares starvation on
//                long dropouts and keeps saturating statistics.
//                Optional feature macro RTDF_GAP_FILL_EN: when defined, each
//                holdover cycle emits an alternating-sign zero-magnitude
//                substitute sample and fill_count counts them; when
//                undefined, holdover cycles emit nothing and fill_count = 0.
//  Revision    : 1.0  initial release
// ============================================================================
module rtdf_sample_conditioner #(
    parameter int STARTUP_RUN  = 16,
    parameter int STARVE_LIMIT = 8,
    parameter int CNT_WIDTH    = 16
) (
    input  wire logic                  clk_sample,
    input  wire logic                  reset,
    rtdf_sample_conditioner_if.slave   bus
);

    localparam logic [1:0] c_ST_ACQUIRE  = 2'd0;
    localparam logic [1:0] c_ST_LOCKED   = 2'd1;
    localparam logic [1:0] c_ST_HOLDOVER = 2'd2;
    localparam logic [1:0] c_ST_STARVED  = 2'd3;

    // 9-bit so that run+1 can be compared without overflow at run=255
    localparam logic [8:0] c_RUN_TARGET  = 9'(STARTUP_RUN);
    localparam logic [7:0] c_GAP_LIMIT   = 8'(STARVE_LIMIT);
    localparam logic [CNT_WIDTH-1:0] c_CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    // Saturating increment: all-ones is sticky
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : (v + c_CNT_ONE);
    endfunction

    logic [1:0]           state_q, state_d;
    logic [7:0]           run_q, run_d;
    logic [7:0]           gap_q, gap_d;
    logic [CNT_WIDTH-1:0] dropout_q, dropout_d;
    logic [CNT_WIDTH-1:0] starve_q, starve_d;
    logic                 out_valid_q, out_valid_d;
    logic [2:0]           out_data_q, out_data_d;
    logic                 locked_q, locked_d;
    logic                 starved_q, starved_d;

    logic                 w_pass;   // sample passes straight through this cycle
    logic                 w_hold;   // this cycle is a holdover cycle
    logic [8:0]           w_run_inc;

    assign w_run_inc = {1'b0, run_q} + 9'd1;

    // Lock / holdover / starvation state machine and event counters
    always_comb begin
        state_d   = state_q;
        run_d     = run_q;
        gap_d     = gap_q;
        dropout_d = dropout_q;
        starve_d  = starve_q;
        w_pass    = 1'b0;
        w_hold    = 1'b0;
        case (state_q)
            c_ST_ACQUIRE: begin
                if (bus.sample_valid) begin
                    // ">=" so a run of 1 left by STARVED still locks on the
                    // next valid sample when STARTUP_RUN is 1
                    if (w_run_inc >= c_RUN_TARGET) begin
                        state_d = c_ST_LOCKED;
                        run_d   = 8'd0;
                    end else begin
                        run_d   = w_run_inc[7:0];
                    end
                end else begin
                    run_d = 8'd0;
                end
            end
            c_ST_LOCKED: begin
                if (bus.sample_valid) begin
                    w_pass = 1'b1;
                end else begin
                    gap_d     = 8'd1;
                    dropout_d = sat_inc(dropout_q);
                    state_d   = c_ST_HOLDOVER;
                    w_hold    = 1'b1;
                end
            end
            c_ST_HOLDOVER: begin
                if (bus.sample_valid) begin
                    gap_d   = 8'd0;
                    w_pass  = 1'b1;
                    state_d = c_ST_LOCKED;
                end else if ((gap_q + 8'd1) == c_GAP_LIMIT) begin
                    gap_d    = 8'd0;
                    state_d  = c_ST_STARVED;
                    starve_d = sat_inc(starve_q);
                end else begin
                    gap_d  = gap_q + 8'd1;
                    w_hold = 1'b1;
                end
            end
            c_ST_STARVED: begin
                // The sample that ends starvation only restarts acquisition
                if (bus.sample_valid) begin
                    state_d = c_ST_ACQUIRE;
                    run_d   = 8'd1;
                end
            end
            default: begin
                state_d = c_ST_ACQUIRE;
                run_d   = 8'd0;
                gap_d   = 8'd0;
            end
        endcase
    end

`ifdef RTDF_GAP_FILL_EN
    logic                 fill_sign_q, fill_sign_d;
    logic [CNT_WIDTH-1:0] fill_cnt_q, fill_cnt_d;

    // Substitute samples alternate sign so the fill carries zero mean
    always_comb begin
        fill_sign_d = fill_sign_q;
        fill_cnt_d  = fill_cnt_q;
        out_valid_d = w_pass | w_hold;
        out_data_d  = 3'b000;
        if (w_pass) begin
            out_data_d = bus.sample_data;
        end else if (w_hold) begin
            out_data_d  = {fill_sign_q, 2'b00};
            fill_sign_d = ~fill_sign_q;
            fill_cnt_d  = sat_inc(fill_cnt_q);
        end
    end

    // Fill bookkeeping registers
    always_ff @(posedge clk_sample) begin
        if (reset) begin
            fill_sign_q <= 1'b0;
            fill_cnt_q  <= '0;
        end else begin
            fill_sign_q <= fill_sign_d;
            fill_cnt_q  <= fill_cnt_d;
        end
    end

    assign bus.fill_count = fill_cnt_q;
`else
    // Holdover cycles stay silent; w_pass and w_hold never coincide
    always_comb begin
        out_valid_d = w_pass & ~w_hold;
        out_data_d  = w_pass ? bus.sample_data : 3'b000;
    end

    assign bus.fill_count = '0;
`endif

    assign locked_d  = (state_d == c_ST_LOCKED) || (state_d == c_ST_HOLDOVER);
    assign starved_d = (state_d == c_ST_STARVED);

    // State, counters and registered outputs; reset overrides everything
    always_ff @(posedge clk_sample) begin
        if (reset) begin
            state_q     <= c_ST_ACQUIRE;
            run_q       <= 8'd0;
            gap_q       <= 8'd0;
            dropout_q   <= '0;
            starve_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= 3'b000;
            locked_q    <= 1'b0;
            starved_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            run_q       <= run_d;
            gap_q       <= gap_d;
            dropout_q   <= dropout_d;
            starve_q    <= starve_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            locked_q    <= locked_d;
            starved_q   <= starved_d;
        end
    end

    assign bus.out_valid     = out_valid_q;
    assign bus.out_data      = out_data_q;
    assign bus.locked        = locked_q;
    assign bus.starved       = starved_q;
    assign bus.dropout_count = dropout_q;
    assign bus.starve_count  = starve_q;

endmodule
`default_nettype wire

// File: tb/tb_rtdf_sample_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rtdf_sample_conditioner
//  Description : Self-checking bench for rtdf_sample_conditioner. A second
//                instance with 2-bit counters shares the stimulus to exercise
//                counter saturation.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rtdf_sample_conditioner;

`ifdef RTDF_GAP_FILL_EN
    localparam bit FILL = 1'b1;
`else
    localparam bit FILL = 1'b0;
`endif
    localparam int STARTUP_RUN  = 16;
    localparam int STARVE_LIMIT = 8;
    localparam int MAX16        = 65535;
    localparam int MAX2         = 3;

    logic clk_sample = 1'b0;
    logic reset;
    always #5 clk_sample = ~clk_sample;

    rtdf_sample_conditioner_if #(.CNT_WIDTH(16)) bus ();
    rtdf_sample_conditioner_if #(.CNT_WIDTH(2))  sbus ();

    rtdf_sample_conditioner #(.STARTUP_RUN(STARTUP_RUN), .STARVE_LIMIT(STARVE_LIMIT), .CNT_WIDTH(16)) dut (
        .clk_sample (clk_sample),
        .reset      (reset),
        .bus        (bus.slave)
    );

    rtdf_sample_conditioner #(.STARTUP_RUN(STARTUP_RUN), .STARVE_LIMIT(STARVE_LIMIT), .CNT_WIDTH(2)) dut_sat (
        .clk_sample (clk_sample),
        .reset      (reset),
        .bus        (sbus.slave)
    );

    typedef struct {
        bit         ov;
        logic [2:0] od;
        bit         lk;
        bit         sv;
        int         drop;
        int         stv;
        int         fill;
    } exp_t;

    // One stimulus segment plus the status expected after its last cycle
    typedef struct {
        bit v;
        int reps;
        bit lk;
        bit sv;
        int drop;
        int stv;
        int fill;
    } seg_t;

    exp_t sb[$];
    seg_t segs[12];

    int n_vec  = 0;
    int n_fail = 0;

    // Reference model state: 0 acquire, 1 locked, 2 holdover, 3 starved
    int m_state, m_run, m_gap, m_drop, m_stv, m_fill;
    bit m_sign;

    function automatic int sat(input int x, input int mx);
        return (x > mx) ? mx : x;
    endfunction

    function automatic exp_t model(input bit r, input bit v, input logic [2:0] d);
        exp_t e;
        bit   hold;
        e    = '{ov: 1'b0, od: 3'b000, lk: 1'b0, sv: 1'b0, drop: 0, stv: 0, fill: 0};
        hold = 1'b0;
        if (r) begin
            m_state = 0; m_run = 0; m_gap = 0; m_sign = 1'b0;
            m_drop = 0; m_stv = 0; m_fill = 0;
        end else begin
            if (m_state == 0) begin
                if (v) begin
                    m_run = m_run + 1;
                    if (m_run >= STARTUP_RUN) begin m_state = 1; m_run = 0; end
                end else m_run = 0;
            end else if (m_state == 1) begin
                if (v) begin e.ov = 1'b1; e.od = d; end
                else begin m_gap = 1; m_drop = m_drop + 1; m_state = 2; hold = 1'b1; end
            end else if (m_state == 2) begin
                if (v) begin m_gap = 0; e.ov = 1'b1; e.od = d; m_state = 1; end
                else begin
                    m_gap = m_gap + 1;
                    if (m_gap == STARVE_LIMIT) begin m_state = 3; m_stv = m_stv + 1; m_gap = 0; end
                    else hold = 1'b1;
                end
            end else begin
                if (v) begin m_state = 0; m_run = 1; end
            end
            if (hold && FILL) begin
                e.ov   = 1'b1;
                e.od   = {m_sign, 2'b00};
                m_sign = ~m_sign;
                m_fill = m_fill + 1;
            end
        end
        e.lk   = (m_state == 1) || (m_state == 2);
        e.sv   = (m_state == 3);
        e.drop = m_drop;
        e.stv  = m_stv;
        e.fill = m_fill;
        return e;
    endfunction

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Drive one cycle, queue its expected result, compare after the edge
    task automatic step(input bit r, input bit v, input logic [2:0] d);
        exp_t e;
        reset             = r;
        bus.sample_valid  = v;
        bus.sample_data   = d;
        sbus.sample_valid = v;
        sbus.sample_data  = d;
        sb.push_back(model(r, v, d));
        @(posedge clk_sample);
        #1;
        e = sb.pop_front();
        n_vec++;
        check("out_valid", 32'(bus.out_valid), 32'(e.ov));
        if (e.ov) check("out_data", 32'(bus.out_data), 32'(e.od));
        check("locked", 32'(bus.locked), 32'(e.lk));
        check("starved", 32'(bus.starved), 32'(e.sv));
        check("dropout_count", 32'(bus.dropout_count), 32'(sat(e.drop, MAX16)));
        check("starve_count", 32'(bus.starve_count), 32'(sat(e.stv, MAX16)));
        check("fill_count", 32'(bus.fill_count), 32'(sat(e.fill, MAX16)));
        check("sat_dropout_count", 32'(sbus.dropout_count), 32'(sat(e.drop, MAX2)));
        check("sat_starve_count", 32'(sbus.starve_count), 32'(sat(e.stv, MAX2)));
        check("sat_fill_count", 32'(sbus.fill_count), 32'(sat(e.fill, MAX2)));
        check("sat_out_valid", 32'(sbus.out_valid), 32'(e.ov));
    endtask

    initial begin
        int f3, f10;
        f3  = FILL ? 3 : 0;
        f10 = FILL ? 10 : 0;
        //          v   reps lk sv drop stv fill
        segs[0]  = '{1, 16, 1, 0, 0, 0, 0};    // lock after 16 valids
        segs[1]  = '{1,  4, 1, 0, 0, 0, 0};    // pass-through
        segs[2]  = '{0,  3, 1, 0, 1, 0, f3};   // short dropout, in holdover
        segs[3]  = '{1,  2, 1, 0, 1, 0, f3};   // recovered
        segs[4]  = '{0,  8, 0, 1, 2, 1, f10};  // 7 holdover cycles then starved
        segs[5]  = '{1,  1, 0, 0, 2, 1, f10};  // restart acquisition, not output
        segs[6]  = '{0,  1, 0, 0, 2, 1, f10};  // clears run
        segs[7]  = '{1, 15, 0, 0, 2, 1, f10};
        segs[8]  = '{0,  1, 0, 0, 2, 1, f10};  // break after 15 valids
        segs[9]  = '{1, 15, 0, 0, 2, 1, f10};  // 15 of 16 further valids
        segs[10] = '{1,  1, 1, 0, 2, 1, f10};  // 16th locks
        segs[11] = '{1,  3, 1, 0, 2, 1, f10};

        reset = 1'b1;
        bus.sample_valid = 1'b0;  bus.sample_data = 3'b000;
        sbus.sample_valid = 1'b0; sbus.sample_data = 3'b000;
        step(1'b1, 1'b0, 3'd0);
        step(1'b1, 1'b1, 3'd5);
        check("reset_out_data", 32'(bus.out_data), 32'd0);

        for (int i = 0; i < 12; i++) begin
            for (int k = 0; k < segs[i].reps; k++)
                step(1'b0, segs[i].v, 3'($urandom_range(0, 7)));
            check($sformatf("seg%0d_locked", i), 32'(bus.locked), 32'(segs[i].lk));
            check($sformatf("seg%0d_starved", i), 32'(bus.starved), 32'(segs[i].sv));
            check($sformatf("seg%0d_dropout", i), 32'(bus.dropout_count), 32'(segs[i].drop));
            check($sformatf("seg%0d_starve", i), 32'(bus.starve_count), 32'(segs[i].stv));
            check($sformatf("seg%0d_fill", i), 32'(bus.fill_count), 32'(segs[i].fill));
        end

        // Reset pulsed in the middle of a holdover
        step(1'b0, 1'b0, 3'd0);
        step(1'b0, 1'b0, 3'd0);
        check("pre_reset_holdover_locked", 32'(bus.locked), 32'd1);
        step(1'b1, 1'b0, 3'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data", 32'(bus.out_data), 32'd0);
        check("rst_locked", 32'(bus.locked), 32'd0);
        check("rst_dropout", 32'(bus.dropout_count), 32'd0);
        check("rst_fill", 32'(bus.fill_count), 32'd0);
        step(1'b0, 1'b1, 3'd3);
        check("post_rst_acquire_locked", 32'(bus.locked), 32'd0);
        check("post_rst_acquire_out_valid", 32'(bus.out_valid), 32'd0);
        step(1'b0, 1'b0, 3'd0);

        // Five dropouts: 2-bit counter pins at 3, 16-bit counter reaches 5
        for (int k = 0; k < STARTUP_RUN; k++) step(1'b0, 1'b1, 3'($urandom_range(0, 7)));
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b0, 3'd0);
            step(1'b0, 1'b1, 3'($urandom_range(0, 7)));
        end
        check("sat_dropout_hold", 32'(sbus.dropout_count), 32'd3);
        check("wide_dropout", 32'(bus.dropout_count), 32'd5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
